// File: rtl/mac_acc.sv
// Accumulate stage behind the Booth multiplier: sums a packet of signed products
// into a guard-bit-extended accumulator and presents the dot-product with count/overflow.
module mac_acc #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+8,
    parameter int CNT_WIDTH = 8,
    parameter bit SAT       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   mul2acc,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf,
    output logic                 restart
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state_q;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, p;
    logic [ACC_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d, valid_q, restart_q;
    logic                 accept, overflow;

    always_comb begin
        p = {ACC_WIDTH{mul2acc[2*WIDTH-1]}};
        p[2*WIDTH-1:0] = mul2acc;
    end

    // One extra bit lets the top-two-bits test catch overflow in either direction.
    assign sum      = {acc_q[ACC_WIDTH-1], acc_q} + {p[ACC_WIDTH-1], p};
    assign overflow = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

    always_comb begin
        acc_d = sum[ACC_WIDTH-1:0];
        if (overflow && SAT) begin
            acc_d = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    assign ovf_d    = ovf_q | overflow;
    assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign in_ready = rst_n && (state_q != DONE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            restart_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q   <= p;
                        cnt_q   <= CNT_WIDTH'(1);
                        ovf_q   <= 1'b0;
                        state_q <= in_last ? DONE : ACCUM;
                        valid_q <= in_last;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        // A new first beat throws away the partial sum and starts over.
                        if (in_first) begin
                            acc_q     <= p;
                            cnt_q     <= CNT_WIDTH'(1);
                            ovf_q     <= 1'b0;
                            restart_q <= 1'b1;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                            ovf_q <= ovf_d;
                        end
                        if (in_last) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign acc_out   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;
    assign restart   = restart_q;

endmodule

// File: tb/tb_mac_acc.sv
// Bench for mac_acc: three instances (24-bit saturating, 16-bit saturating, 16-bit wrapping)
// share one stimulus stream and are compared against an arithmetic packet model.
module tb_mac_acc;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_first, in_last, out_ready;
    logic [15:0]       mul2acc;
    logic              inReady  [3];
    logic              outValid [3];
    logic              outOvf   [3];
    logic              restartO [3];
    logic [7:0]        cnt      [3];
    logic signed [23:0] acc0;
    logic signed [15:0] acc1, acc2;

    int totalCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Packet model: running value per instance computed with plain integer arithmetic.
    int     accW [3] = '{24, 16, 16};
    bit     satM [3] = '{1'b1, 1'b1, 1'b0};
    longint mAcc [3];
    bit     mOvf [3];
    int     mCnt;
    bit     mDone, mInPkt, mRestart;
    bit     accepted;

    always #5 clk = ~clk;

    mac_acc u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady[0]),
        .mul2acc(mul2acc), .in_first(in_first), .in_last(in_last),
        .out_valid(outValid[0]), .out_ready(out_ready), .acc_out(acc0),
        .out_count(cnt[0]), .out_ovf(outOvf[0]), .restart(restartO[0])
    );

    mac_acc #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8), .SAT(1'b1)) u_sat16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady[1]),
        .mul2acc(mul2acc), .in_first(in_first), .in_last(in_last),
        .out_valid(outValid[1]), .out_ready(out_ready), .acc_out(acc1),
        .out_count(cnt[1]), .out_ovf(outOvf[1]), .restart(restartO[1])
    );

    mac_acc #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8), .SAT(1'b0)) u_wrap16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady[2]),
        .mul2acc(mul2acc), .in_first(in_first), .in_last(in_last),
        .out_valid(outValid[2]), .out_ready(out_ready), .acc_out(acc2),
        .out_count(cnt[2]), .out_ovf(outOvf[2]), .restart(restartO[2])
    );

    function automatic logic signed [63:0] accOf(int i);
        logic signed [63:0] v;
        case (i)
            0:       v = acc0;
            1:       v = acc1;
            default: v = acc2;
        endcase
        return v;
    endfunction

    function automatic longint wrapTo(longint v, int w);
        longint m, r;
        m = longint'(1) <<< w;
        r = v % m;
        if (r >= (m >>> 1))  r = r - m;
        if (r < -(m >>> 1))  r = r + m;
        return r;
    endfunction

    task automatic checkOutput(string tag, logic signed [63:0] observed, logic signed [63:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelAccept(longint p, bit first, bit last);
        longint s, hi, lo;
        if (!mInPkt || first) begin
            mRestart = mInPkt && first;
            mCnt = 1;
            for (int i = 0; i < 3; i++) begin
                mAcc[i] = p;
                mOvf[i] = 1'b0;
            end
        end else begin
            mCnt = (mCnt < 255) ? mCnt + 1 : 255;
            for (int i = 0; i < 3; i++) begin
                hi = (longint'(1) <<< (accW[i] - 1)) - 1;
                lo = -(longint'(1) <<< (accW[i] - 1));
                s  = mAcc[i] + p;
                if (s > hi || s < lo) begin
                    mOvf[i] = 1'b1;
                    mAcc[i] = satM[i] ? ((s > hi) ? hi : lo) : wrapTo(s, accW[i]);
                end else begin
                    mAcc[i] = s;
                end
            end
        end
        if (last) begin
            mDone  = 1'b1;
            mInPkt = 1'b0;
        end else begin
            mInPkt = 1'b1;
        end
    endtask

    // One clock: check ready before the edge, advance the model at the edge, check after.
    task automatic cycle();
        bit accE, handE;
        for (int i = 0; i < 3; i++) checkOutput("in_ready", inReady[i], !mDone);
        accE = in_valid && !mDone;
        handE = out_ready && mDone;
        @(posedge clk);
        mRestart = 1'b0;
        if (handE) mDone = 1'b0;
        if (accE) modelAccept(longint'($signed(mul2acc)), in_first, in_last);
        accepted = accE;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("out_valid", outValid[i], mDone);
            checkOutput("restart", restartO[i], mRestart);
            if (mDone) begin
                checkOutput("acc_out", accOf(i), mAcc[i]);
                checkOutput("out_count", cnt[i], mCnt);
                checkOutput("out_ovf", outOvf[i], mOvf[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(bit v, logic [15:0] d, bit f, bit l, bit rdy);
        in_valid  = v;
        mul2acc   = d;
        in_first  = f;
        in_last   = l;
        out_ready = rdy;
        cycle();
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) checkOutput("rst_in_ready", inReady[i], 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_out_valid", outValid[i], 0);
            checkOutput("rst_acc", accOf(i), 0);
            checkOutput("rst_count", cnt[i], 0);
            checkOutput("rst_ovf", outOvf[i], 0);
            checkOutput("rst_restart", restartO[i], 0);
            checkOutput("rst_in_ready_hold", inReady[i], 0);
        end
        mDone = 1'b0; mInPkt = 1'b0; mRestart = 1'b0; mCnt = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", inReady[0], 1);
    endtask

    initial begin
        in_valid = 0; in_first = 0; in_last = 0; out_ready = 0; mul2acc = '0;
        rst_n = 1'b0;
        @(negedge clk);
        doReset();
        @(negedge clk);

        $display("[TB] single-term packet");
        applyStimulus(1, 16'h000C, 1, 1, 0);
        checkOutput("t1_acc", acc0, 12);
        checkOutput("t1_count", cnt[0], 1);
        checkOutput("t1_ovf", outOvf[0], 0);
        applyStimulus(0, 16'h0000, 0, 0, 1);
        checkOutput("t1_ready_after", inReady[0], 1);

        $display("[TB] back-to-back packet and backpressure");
        applyStimulus(1, 16'd12, 1, 0, 0);
        checkOutput("t2_beat1", accepted, 1);
        applyStimulus(1, 16'hFFDD, 0, 0, 0);
        checkOutput("t2_beat2", accepted, 1);
        applyStimulus(1, 16'd100, 0, 1, 0);
        checkOutput("t2_beat3", accepted, 1);
        checkOutput("t2_acc", acc0, 77);
        checkOutput("t2_count", cnt[0], 3);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 16'd5, 1, 1, 0);
            checkOutput("t3_held", accepted, 0);
            checkOutput("t3_acc_stable", acc0, 77);
        end
        applyStimulus(1, 16'd5, 1, 1, 1);
        checkOutput("t3_handoff_no_accept", accepted, 0);
        applyStimulus(1, 16'd5, 1, 1, 0);
        checkOutput("t3_accept_after", accepted, 1);
        applyStimulus(0, 16'd0, 0, 0, 1);

        $display("[TB] overflow");
        applyStimulus(1, 16'h4000, 1, 0, 0);
        applyStimulus(1, 16'h4000, 0, 1, 0);
        checkOutput("t4_sat_pos", acc1, 32767);
        checkOutput("t4_wrap_pos", acc2, -32768);
        checkOutput("t4_ovf_sat", outOvf[1], 1);
        checkOutput("t4_ovf_wrap", outOvf[2], 1);
        checkOutput("t4_wide_acc", acc0, 32768);
        checkOutput("t4_wide_ovf", outOvf[0], 0);
        applyStimulus(0, 16'd0, 0, 0, 1);
        applyStimulus(1, 16'hC000, 1, 0, 0);
        applyStimulus(1, 16'hC000, 0, 0, 0);
        applyStimulus(1, 16'hC000, 0, 1, 0);
        checkOutput("t4_sat_neg", acc1, -32768);
        checkOutput("t4_ovf_neg", outOvf[1], 1);
        applyStimulus(0, 16'd0, 0, 0, 1);

        $display("[TB] restart");
        applyStimulus(1, 16'd10, 1, 0, 0);
        applyStimulus(1, 16'd20, 0, 0, 0);
        applyStimulus(1, 16'd5, 1, 1, 0);
        checkOutput("t5_restart", restartO[0], 1);
        checkOutput("t5_acc", acc0, 5);
        checkOutput("t5_count", cnt[0], 1);
        checkOutput("t5_ovf", outOvf[0], 0);
        applyStimulus(0, 16'd0, 0, 0, 1);
        checkOutput("t5_restart_gone", restartO[0], 0);

        $display("[TB] reset mid-packet");
        applyStimulus(1, 16'd3, 1, 0, 0);
        applyStimulus(1, 16'd4, 0, 0, 0);
        doReset();
        @(negedge clk);
        applyStimulus(1, 16'd7, 1, 1, 0);
        checkOutput("t6_acc", acc0, 7);
        checkOutput("t6_count", cnt[0], 1);
        applyStimulus(0, 16'd0, 0, 0, 1);

        $display("[TB] count saturation");
        applyStimulus(1, 16'd1, 1, 0, 0);
        for (int k = 0; k < 258; k++) applyStimulus(1, 16'd1, 0, 0, 0);
        applyStimulus(1, 16'd1, 0, 1, 0);
        checkOutput("cnt_sat", cnt[0], 255);
        checkOutput("cnt_sat_acc", acc0, 260);
        applyStimulus(0, 16'd0, 0, 0, 1);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom % 4) != 0, 16'($urandom),
                          ($urandom % 5) == 0, ($urandom % 4) == 0,
                          ($urandom % 3) != 0);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
